// File: rtl/dmem_responder.sv
// dmem_responder: stall-capable data memory responder for the core load/store port.
// One request in flight at a time. After acceptance the access waits LATENCY
// cycles (0..15), executes against a little-endian word array, and the
// response is held until the requester takes it.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | ready for a new request (req_ready = 1 while out of reset)
//   WAIT  | request latched, wait-state counter running down
//   RESP  | response presented, held until resp_ready
module dmem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic        req_we_word,
   input  logic        req_we_byte,
   input  logic        req_re,
   input  logic [2:0]  req_funct3,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS * 4);
   localparam logic [3:0]  LAT_LOAD   = 4'(LATENCY);
   localparam logic [2:0]  F3_LW      = 3'b010;
   localparam logic [2:0]  F3_LBU     = 3'b100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic [31:0] mem [DEPTH_WORDS];

   logic [31:0] l_addr, l_wdata;
   logic        l_we_word, l_we_byte, l_re;
   logic [2:0]  l_funct3;

   logic [31:0] a_addr, a_wdata;
   logic        a_we_word, a_we_byte, a_re;
   logic [2:0]  a_funct3;

   logic             accept, exec;
   logic             a_onehot, a_range, a_misalign, a_badf3, a_err;
   logic [IDX_W-1:0] a_idx;
   logic [31:0]      a_word, a_rdata;
   logic [7:0]       a_byte;

   assign req_ready = rst && (state == IDLE);
   assign accept    = req_valid && req_ready;

   // The access happens either at the acceptance edge (zero latency) or on the
   // last wait cycle; reset on that edge suppresses it.
   assign exec = rst && (((state == IDLE) && accept && (LATENCY == 0)) ||
                         ((state == WAIT) && (cnt == 4'd1)));

   // Operand select: live request fields in IDLE, latched copy afterwards.
   always_comb begin
      if (state == IDLE) begin
         a_addr    = req_addr;
         a_wdata   = req_wdata;
         a_we_word = req_we_word;
         a_we_byte = req_we_byte;
         a_re      = req_re;
         a_funct3  = req_funct3;
      end else begin
         a_addr    = l_addr;
         a_wdata   = l_wdata;
         a_we_word = l_we_word;
         a_we_byte = l_we_byte;
         a_re      = l_re;
         a_funct3  = l_funct3;
      end
   end

   // Legality decode and read-data formatting for the selected access.
   always_comb begin
      a_onehot   = ({a_we_word, a_we_byte, a_re} == 3'b100) ||
                   ({a_we_word, a_we_byte, a_re} == 3'b010) ||
                   ({a_we_word, a_we_byte, a_re} == 3'b001);
      a_range    = (a_addr < ADDR_LIMIT);
      a_misalign = (a_we_word || (a_re && (a_funct3 == F3_LW))) && (a_addr[1:0] != 2'b00);
      a_badf3    = a_re && (a_funct3 != F3_LW) && (a_funct3 != F3_LBU);
      a_err      = !a_onehot || !a_range || a_misalign || a_badf3;
      a_idx      = a_addr[IDX_W+1:2];
      a_word     = mem[a_idx];
      a_byte     = a_word[{a_addr[1:0], 3'b000} +: 8];
      a_rdata    = 32'd0;
      if (!a_err && a_re) begin
         a_rdata = (a_funct3 == F3_LBU) ? {24'd0, a_byte} : a_word;
      end
   end

   // Capture the request so later input changes cannot affect it.
   always_ff @(posedge clk) begin
      if (accept) begin
         l_addr    <= req_addr;
         l_wdata   <= req_wdata;
         l_we_word <= req_we_word;
         l_we_byte <= req_we_byte;
         l_re      <= req_re;
         l_funct3  <= req_funct3;
      end
   end

   // Array writes; contents survive reset, illegal requests never write.
   always_ff @(posedge clk) begin
      if (exec && !a_err) begin
         if (a_we_word) begin
            mem[a_idx] <= a_wdata;
         end else if (a_we_byte) begin
            mem[a_idx][{a_addr[1:0], 3'b000} +: 8] <= a_wdata[7:0];
         end
      end
   end

   // Control FSM with registered response outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         resp_valid <= 1'b0;
         resp_rdata <= 32'd0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (LATENCY == 0) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_rdata <= a_rdata;
                     resp_err   <= a_err;
                  end else begin
                     state <= WAIT;
                     cnt   <= LAT_LOAD;
                  end
               end
            end
            WAIT: begin
               if (cnt == 4'd1) begin
                  state      <= RESP;
                  cnt        <= 4'd0;
                  resp_valid <= 1'b1;
                  resp_rdata <= a_rdata;
                  resp_err   <= a_err;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  state      <= IDLE;
                  resp_valid <= 1'b0;
                  resp_rdata <= 32'd0;
                  resp_err   <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= 4'd0;
            end
         endcase
      end
   end

endmodule
